first_match_range_chk: RTL and testbench



---
 rtl/first_match_range_chk.sv | 92 +++++++++
 tb/tb_first_match_range_chk.sv | 175 +++++++++++++++++
 2 files changed

// File: rtl/first_match_range_chk.sv
// first_match_range_chk: checks start ##[MIN_DLY:MAX_DLY] done with first_match semantics,
// reporting registered pass/fail/drop/abort pulses, match latency and saturating counters.
module first_match_range_chk #(
    parameter int MIN_DLY = 1,
    parameter int MAX_DLY = 4,
    parameter int DLY_W   = 8,
    parameter int CNT_W   = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             dis,
    input  logic             start,
    input  logic             done,
    output logic             busy,
    output logic             pass,
    output logic             fail,
    output logic             drop,
    output logic             abort,
    output logic [DLY_W-1:0] latency,
    output logic [CNT_W-1:0] pass_cnt,
    output logic [CNT_W-1:0] fail_cnt,
    output logic [CNT_W-1:0] drop_cnt
);
    typedef enum logic {IDLE, WAIT} state_t;

    state_t state, state_nx;
    logic [DLY_W-1:0] dly, dly_nx, latency_nx;
    logic pass_nx, fail_nx, drop_nx, abort_nx, dly_ok;

    // dly >= MIN_DLY, written so that MIN_DLY == 0 is not a constant-true compare
    assign dly_ok = ({1'b0, dly} + (DLY_W+1)'(1)) > (DLY_W+1)'(MIN_DLY);
    assign busy   = (state == WAIT);

    always_comb begin
        state_nx   = state;
        dly_nx     = dly;
        latency_nx = latency;
        pass_nx    = 1'b0;
        fail_nx    = 1'b0;
        abort_nx   = 1'b0;
        drop_nx    = (state == WAIT) && start;
        if (state == IDLE) begin
            if (start && !dis) begin
                if (MIN_DLY == 0 && done) begin
                    pass_nx    = 1'b1;
                    latency_nx = '0;
                end else begin
                    state_nx = WAIT;
                    dly_nx   = DLY_W'(1);
                end
            end
        end else if (dis) begin
            abort_nx = 1'b1;
            state_nx = IDLE;
        end else if (done && dly_ok) begin
            pass_nx    = 1'b1;
            latency_nx = dly;
            state_nx   = IDLE;
        end else if (dly == DLY_W'(MAX_DLY)) begin
            fail_nx  = 1'b1;
            state_nx = IDLE;
        end else begin
            dly_nx = dly + 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= IDLE;
            dly      <= '0;
            latency  <= '0;
            pass     <= 1'b0;
            fail     <= 1'b0;
            drop     <= 1'b0;
            abort    <= 1'b0;
            pass_cnt <= '0;
            fail_cnt <= '0;
            drop_cnt <= '0;
        end else begin
            state    <= state_nx;
            dly      <= dly_nx;
            latency  <= latency_nx;
            pass     <= pass_nx;
            fail     <= fail_nx;
            drop     <= drop_nx;
            abort    <= abort_nx;
            pass_cnt <= pass_cnt + CNT_W'(pass_nx && !(&pass_cnt));
            fail_cnt <= fail_cnt + CNT_W'(fail_nx && !(&fail_cnt));
            drop_cnt <= drop_cnt + CNT_W'(drop_nx && !(&drop_cnt));
        end
    end
endmodule

// File: tb/tb_first_match_range_chk.sv
// tb_first_match_range_chk: scoreboard bench; expected pulses are queued with their edge number
// and matched against DUT pulses as they appear, plus direct checks of counters and latency.
module tb_first_match_range_chk;
    logic clk = 0, rst_n = 0, start = 0, done = 0, dis = 0;
    logic busy, pass, fail, drop, abort;
    logic [7:0] latency;
    logic [15:0] pass_cnt, fail_cnt, drop_cnt;

    logic start_b = 0, done_b = 0, dis_b = 0;
    logic busy_b, pass_b, fail_b, drop_b, abort_b;
    logic [7:0] latency_b;
    logic [1:0] pass_cnt_b, fail_cnt_b, drop_cnt_b;

    int errors = 0, checks = 0, cyc = 0;
    int q[$];

    first_match_range_chk dut (
        .clk(clk), .rst_n(rst_n), .dis(dis), .start(start), .done(done),
        .busy(busy), .pass(pass), .fail(fail), .drop(drop), .abort(abort),
        .latency(latency), .pass_cnt(pass_cnt), .fail_cnt(fail_cnt), .drop_cnt(drop_cnt)
    );

    // zero minimum delay, narrow counters to reach saturation quickly
    first_match_range_chk #(.MIN_DLY(0), .MAX_DLY(4), .DLY_W(8), .CNT_W(2)) dut_b (
        .clk(clk), .rst_n(rst_n), .dis(dis_b), .start(start_b), .done(done_b),
        .busy(busy_b), .pass(pass_b), .fail(fail_b), .drop(drop_b), .abort(abort_b),
        .latency(latency_b), .pass_cnt(pass_cnt_b), .fail_cnt(fail_cnt_b), .drop_cnt(drop_cnt_b)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    // event code: edge * 4096 + kind * 256 + latency; kind 0=pass 1=fail 2=drop 3=abort
    task automatic expect_ev(input int k, input int kind, input int lat);
        q.push_back((cyc + k) * 4096 + kind * 256 + lat);
    endtask

    task automatic mon(input int kind, input int lat);
        int obs;
        obs = cyc * 4096 + kind * 256 + lat;
        if (q.size() == 0) chk("unexpected_ev", obs, 0);
        else chk("event", obs, q.pop_front());
    endtask

    always @(posedge clk) begin
        #1;
        if (rst_n) begin
            if (pass)  mon(0, int'(latency));
            if (fail)  mon(1, 0);
            if (abort) mon(3, 0);
            if (drop)  mon(2, 0);
        end
    end

    task automatic step(input logic s, input logic d, input logic x);
        @(negedge clk);
        start = s;
        done  = d;
        dis   = x;
        @(posedge clk);
        cyc++;
    endtask

    task automatic scn(input logic [15:0] st, input logic [15:0] dn, input logic [15:0] ds, input int n);
        for (int k = 1; k <= n; k++) step(st[k], dn[k], ds[k]);
    endtask

    task automatic settle();
        repeat (6) step(0, 0, 0);
        #2;
        chk("leftover", q.size(), 0);
    endtask

    task automatic step_b(input logic s, input logic d);
        @(negedge clk);
        start_b = s;
        done_b  = d;
        @(posedge clk);
        #1;
    endtask

    initial begin
        repeat (2) @(posedge clk);
        #1;
        chk("rst_busy", busy, 0);
        chk("rst_latency", latency, 0);
        chk("rst_pass_cnt", pass_cnt, 0);
        chk("rst_fail_cnt", fail_cnt, 0);
        @(negedge clk);
        rst_n = 1;
        // no done: fail at d=MAX_DLY
        expect_ev(5, 1, 0);
        scn(16'h0002, 16'h0000, 16'h0000, 6);
        settle();
        chk("t2_fail_cnt", fail_cnt, 1);
        chk("t2_latency", latency, 0);
        // done at d=3
        expect_ev(4, 0, 3);
        scn(16'h0002, 16'h0010, 16'h0000, 4);
        #1;
        chk("t1_busy", busy, 0);
        chk("t1_latency", latency, 3);
        chk("t1_pass_cnt", pass_cnt, 1);
        settle();
        // done at d=0 ignored, first match at d=1
        expect_ev(2, 0, 1);
        scn(16'h0002, 16'h000E, 16'h0000, 4);
        settle();
        chk("t3_latency", latency, 1);
        // second start dropped, pass at d=MAX_DLY
        expect_ev(3, 2, 0);
        expect_ev(5, 0, 4);
        scn(16'h000A, 16'h0020, 16'h0000, 5);
        settle();
        chk("t4_drop_cnt", drop_cnt, 1);
        chk("t4_latency", latency, 4);
        // disable aborts; start under disable ignored
        expect_ev(3, 3, 0);
        scn(16'h0042, 16'h0010, 16'h0048, 7);
        settle();
        chk("t5_pass_cnt", pass_cnt, 3);
        chk("t5_fail_cnt", fail_cnt, 1);
        // start on the expiry edge: fail and drop together
        expect_ev(5, 1, 0);
        expect_ev(5, 2, 0);
        scn(16'h0022, 16'h0000, 16'h0000, 6);
        settle();
        chk("t6_fail_cnt", fail_cnt, 2);
        chk("t6_drop_cnt", drop_cnt, 2);
        // reset mid-attempt
        step(1, 0, 0);
        step(0, 0, 0);
        #1;
        chk("mid_busy", busy, 1);
        @(negedge clk);
        rst_n = 0;
        #1;
        chk("arst_busy", busy, 0);
        chk("arst_pass_cnt", pass_cnt, 0);
        chk("arst_drop_cnt", drop_cnt, 0);
        chk("arst_latency", latency, 0);
        @(negedge clk);
        rst_n = 1;
        expect_ev(4, 0, 3);
        scn(16'h0002, 16'h0010, 16'h0000, 4);
        settle();
        chk("fresh_pass_cnt", pass_cnt, 1);
        chk("fresh_fail_cnt", fail_cnt, 0);
        // MIN_DLY=0 instance: immediate pass stays idle, counter saturates
        for (int i = 0; i < 5; i++) begin
            step_b(1, 1);
            chk("b_pass", pass_b, 1);
            chk("b_busy", busy_b, 0);
            chk("b_latency", latency_b, 0);
        end
        step_b(0, 0);
        chk("b_pass_cnt_sat", pass_cnt_b, 3);
        step_b(1, 0);
        chk("b_wait_busy", busy_b, 1);
        step_b(0, 1);
        chk("b_pass_d1", pass_b, 1);
        chk("b_latency_d1", latency_b, 1);
        chk("b_fail_cnt", fail_cnt_b, 0);
        step_b(0, 0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
